md_sequencer: RTL and testbench
===============================

// Module: md_sequencer
// PURPOSE
//  Multiply/divide sequencer for the E stage of the 5-stage MIPS pipeline. Accepts
//  MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from E, owns the HI/LO registers, and models
//  multi-cycle latency with a busy counter. Raises stall_req toward the hazard unit
//  while a D-stage instruction needs the unit and the unit is occupied.
// PARAMETERS
//  MULT_LAT  5   busy cycles for MULT/MULTU (>=1)
//  DIV_LAT   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk        in   1   pipeline clock
//  reset      in   1   synchronous, active-low reset
//  start      in   1   E-stage md instruction valid this cycle
//  md_op      in   3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//  rs_val     in   32  forwarded rs operand
//  rt_val     in   32  forwarded rt operand
//  md_use_D   in   1   D-stage instr is mult/div/mfhi/mflo/mthi/mtlo
//  busy       out  1   registered; operation in progress
//  stall_req  out  1   combinational stall request to hazard unit
//  done       out  1   registered one-cycle pulse, HI/LO just updated by mult/div
//  hi         out  32  HI register
//  lo         out  32  LO register
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state IDLE, count=0, busy=0, done=0, hi=0, lo=0.
//    Reset mid-operation aborts it; HI/LO cleared, no done pulse.
//  - States: IDLE, RUN. Down-counter count, width clog2(max(MULT_LAT,DIV_LAT))+1.
//  - IDLE & start & md_op in {MULT..DIVU} at edge t: latch operands and op,
//    count<=LAT of op, ->RUN. busy=1 cycles t+1..t+LAT.
//  - RUN: count decrements each edge; at edge with count==1: write HI/LO, ->IDLE,
//    busy<=0, done<=1. New HI/LO visible cycle t+LAT+1, done high that cycle only.
//  - IDLE & start & MTHI: hi<=rs_val next edge; MTLO: lo<=rs_val. No busy, no done.
//  - start while RUN: ignored (hazard unit guarantees none); operands not relatched.
//  - md_op 110/111 with start: no-op.
//  - Arithmetic, computed on latched operands:
//    MULT  {hi,lo}=$signed(rs)*$signed(rt), 64-bit;  MULTU unsigned 64-bit.
//    DIV   lo=signed quotient truncated toward zero, hi=remainder with sign of rs.
//    DIVU  lo=unsigned quotient, hi=unsigned remainder.
//    rt==0 for DIV/DIVU: full DIV_LAT busy period, done pulses, HI/LO unchanged.
//    DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no trap).
//  - stall_req = md_use_D & (busy | (start & md_op<=3'b011)). Purely combinational.
//  - done and busy never both 1 in the same cycle.
// TESTING
//  1 MULT rs=3 rt=0xFFFFFFFE -> busy 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFA, done 1 cycle.
//  2 MULTU rs=rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE lo=0x00000001.
//  3 DIV rs=0xFFFFFFF9(-7) rt=2 -> busy 10 cycles, lo=0xFFFFFFFD hi=0xFFFFFFFF;
//    DIVU 7/2 -> lo=3 hi=1.
//  4 DIVU rt=0 with hi=0x11 lo=0x22 -> busy 10 cycles, done pulses, hi/lo stay 0x11/0x22.
//  5 MTHI rs=0xABCD then MTLO rs=0x1234 back-to-back -> hi=0xABCD, lo=0x1234, busy stays 0;
//    md_use_D=1 during MULT busy -> stall_req=1 every busy cycle, 0 in the done cycle.
//  6 reset=0 at 3rd busy cycle of DIV -> next cycle busy=0, done=0, hi=lo=0; start
//    ignored while busy (second start mid-MULT leaves result of first).

Source files
------------

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models MULT/DIV latency
// with a down-counter and requests a stall while the unit is occupied.
module md_sequencer #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [2:0]    op_reg, op_next;
  logic [31:0]   rs_reg, rs_next;
  logic [31:0]   rt_reg, rt_next;
  logic [31:0]   hi_reg, hi_next;
  logic [31:0]   lo_reg, lo_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;

  // One shared multiplier: signed ops sign-extend to 64 bits, unsigned ops zero-extend.
  logic        op_signed;
  logic [63:0] mul_a, mul_b, product;

  assign op_signed = ~op_reg[0];
  assign mul_a     = {{32{op_signed & rs_reg[31]}}, rs_reg};
  assign mul_b     = {{32{op_signed & rt_reg[31]}}, rt_reg};
  assign product   = mul_a * mul_b;

  // Divide on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag, divisor, uquot, urem, quot, rem;

  assign rs_neg  = op_signed & rs_reg[31];
  assign rt_neg  = op_signed & rt_reg[31];
  assign rs_mag  = rs_neg ? (~rs_reg + 32'd1) : rs_reg;
  assign rt_mag  = rt_neg ? (~rt_reg + 32'd1) : rt_reg;
  assign divisor = (rt_reg == 32'd0) ? 32'd1 : rt_mag;
  assign uquot   = rs_mag / divisor;
  assign urem    = rs_mag % divisor;
  assign quot    = (rs_neg ^ rt_neg) ? (~uquot + 32'd1) : uquot;
  assign rem     = rs_neg ? (~urem + 32'd1) : urem;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    op_next    = op_reg;
    rs_next    = rs_reg;
    rt_next    = rt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (!md_op[2]) begin
            op_next    = md_op;
            rs_next    = rs_val;
            rt_next    = rt_val;
            count_next = md_op[1] ? CW'(DIV_LAT) : CW'(MULT_LAT);
            busy_next  = 1'b1;
            state_next = RUN;
          end else if (md_op == OP_MTHI) begin
            hi_next = rs_val;
          end else if (md_op == OP_MTLO) begin
            lo_next = rs_val;
          end
        end
      end
      RUN: begin
        if (count_reg == CW'(1)) begin
          state_next = IDLE;
          count_next = '0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          if (!op_reg[1]) begin
            hi_next = product[63:32];
            lo_next = product[31:0];
          end else if (rt_reg != 32'd0) begin
            hi_next = rem;
            lo_next = quot;
          end
        end else begin
          count_next = count_reg - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      op_reg    <= '0;
      rs_reg    <= '0;
      rt_reg    <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      op_reg    <= op_next;
      rs_reg    <= rs_next;
      rt_reg    <= rt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign hi        = hi_reg;
  assign lo        = lo_reg;
  assign stall_req = md_use_D & (busy_reg | (start & (md_op <= 3'b011)));

endmodule

// File: tb/tb_md_sequencer.sv
// Directed table-driven bench for md_sequencer, plus hand sequences for
// reset mid-operation and start-while-busy.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        md_use_D;
  logic        busy, stall_req, done;
  logic [31:0] hi, lo;

  md_sequencer #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_use_D (md_use_D),
    .busy     (busy),
    .stall_req(stall_req),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        use_d;
    int          lat;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic use_d, input int lat,
                         input logic [31:0] eh, input logic [31:0] el);
    vec_t v;
    v.op = op; v.rs = rs; v.rt = rt; v.use_d = use_d; v.lat = lat;
    v.exp_hi = eh; v.exp_lo = el;
    vq.push_back(v);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1; issues the op in the current cycle.
  task automatic run_vec(input vec_t v, input int idx);
    start = 1'b1; md_op = v.op; rs_val = v.rs; rt_val = v.rt; md_use_D = v.use_d;
    #1;
    chk("stall_issue", {31'd0, stall_req}, {31'd0, v.use_d & (v.op <= 3'b011)});
    tick();
    start = 1'b0;
    if (v.lat > 0) begin
      for (int k = 1; k <= v.lat; k++) begin
        chk("busy_run", {31'd0, busy}, 32'd1);
        chk("done_run", {31'd0, done}, 32'd0);
        chk("stall_run", {31'd0, stall_req}, {31'd0, v.use_d});
        tick();
      end
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("busy_done", {31'd0, busy}, 32'd0);
      chk("stall_done", {31'd0, stall_req}, 32'd0);
      chk("hi", hi, v.exp_hi);
      chk("lo", lo, v.exp_lo);
      tick();
      chk("done_clear", {31'd0, done}, 32'd0);
    end else begin
      chk("busy_imm", {31'd0, busy}, 32'd0);
      chk("done_imm", {31'd0, done}, 32'd0);
      chk("hi", hi, v.exp_hi);
      chk("lo", lo, v.exp_lo);
    end
    $display("vec %0d op=%0d rs=%h rt=%h -> hi=%h lo=%h", idx, v.op, v.rs, v.rt, hi, lo);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; start = 1'b0; md_op = 3'b000; rs_val = '0; rt_val = '0; md_use_D = 1'b0;

    //       op      rs            rt            use lat  exp_hi        exp_lo
    add_vec(3'b000, 32'd3,        32'hFFFFFFFE, 1'b1, 5,  32'hFFFFFFFF, 32'hFFFFFFFA);
    add_vec(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5,  32'hFFFFFFFE, 32'h00000001);
    add_vec(3'b010, 32'hFFFFFFF9, 32'd2,        1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    add_vec(3'b011, 32'd7,        32'd2,        1'b0, 10, 32'd1,        32'd3);
    add_vec(3'b100, 32'h11,       32'd0,        1'b1, 0,  32'h11,       32'd3);
    add_vec(3'b101, 32'h22,       32'd0,        1'b1, 0,  32'h11,       32'h22);
    add_vec(3'b011, 32'd5,        32'd0,        1'b1, 10, 32'h11,       32'h22);
    add_vec(3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b1, 10, 32'd0,        32'h80000000);
    add_vec(3'b100, 32'hABCD,     32'd0,        1'b0, 0,  32'hABCD,     32'h80000000);
    add_vec(3'b101, 32'h1234,     32'd0,        1'b0, 0,  32'hABCD,     32'h1234);
    add_vec(3'b000, 32'hFFFFFFFB, 32'hFFFFFFF9, 1'b0, 5,  32'd0,        32'd35);
    add_vec(3'b010, 32'd7,        32'hFFFFFFFE, 1'b1, 10, 32'd1,        32'hFFFFFFFD);
    add_vec(3'b110, 32'h5555,     32'h6666,     1'b1, 0,  32'd1,        32'hFFFFFFFD);
    add_vec(3'b001, 32'h10000,    32'h10000,    1'b1, 5,  32'd1,        32'd0);

    // Reset state
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;
    tick();

    foreach (vq[i]) run_vec(vq[i], i);
    tick();

    // Reset asserted in the 3rd busy cycle of a DIV aborts it and clears HI/LO.
    start = 1'b1; md_op = 3'b010; rs_val = 32'd100; rt_val = 32'd3; md_use_D = 1'b0;
    tick();
    start = 1'b0;
    chk("abort_busy1", {31'd0, busy}, 32'd1);
    tick();
    chk("abort_busy2", {31'd0, busy}, 32'd1);
    tick();
    chk("abort_busy3", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("abort_nodone", {31'd0, done}, 32'd0);
    end
    $display("seq abort: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);

    // A second start two cycles into a MULT must not disturb the first result.
    start = 1'b1; md_op = 3'b000; rs_val = 32'd3; rt_val = 32'd4; md_use_D = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_busy1", {31'd0, busy}, 32'd1);
    tick();
    start = 1'b1; md_op = 3'b001; rs_val = 32'hFFFFFFFF; rt_val = 32'hFFFFFFFF;
    #1;
    chk("ign_stall", {31'd0, stall_req}, 32'd1);
    tick();
    start = 1'b0;
    chk("ign_busy3", {31'd0, busy}, 32'd1);
    tick(); tick();
    chk("ign_busy5", {31'd0, busy}, 32'd1);
    chk("ign_hi_hold", hi, 32'd0);
    tick();
    chk("ign_done", {31'd0, done}, 32'd1);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd12);
    tick();
    chk("ign_idle", {31'd0, busy}, 32'd0);
    chk("ign_done_clr", {31'd0, done}, 32'd0);
    $display("seq ignore: hi=%h lo=%h busy=%b", hi, lo, busy);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
